// File: rtl/error_checker_controller_pkg.sv
// Shared controller constants: state encodings for the residual-check controller.
// Contents:
//   ctrl_state_e - 3-bit FSM state encoding (value 3'd7 is unused/illegal)
//   StateW       - width of the state register
//   state_busy   - decode of the busy indication from a state value
package error_checker_controller_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle     = 3'd0,
        StWaitCoef = 3'd1,
        StInit     = 3'd2,
        StLdXy     = 3'd3,
        StCalc     = 3'd4,
        StOut      = 3'd5,
        StDone     = 3'd6
    } ctrl_state_e;

    // A pass is in progress in every legal state past the coefficient wait.
    function automatic logic state_busy(input ctrl_state_e s);
        unique case (s)
            StInit, StLdXy, StCalc, StOut, StDone: state_busy = 1'b1;
            default:                               state_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/error_checker_controller_counter_modn.sv
// Modulo-N counter with synchronous clear, enable and terminal-count flag.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset (count to 0)
//   clr_i    - synchronous clear (count to 0), has priority over enable
//   en_i     - advance the count; wraps N-1 -> 0
//   count_o  - current count
//   co_o     - carry-out / terminal flag, high while count == N-1
module error_checker_controller_counter_modn #(
    parameter int unsigned N  = 150,
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] count_o,
    output logic          co_o
);

    localparam logic [AW-1:0] Last = AW'(N - 1);

    logic [AW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == Last) ? '0 : count_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign co_o    = (count_q == Last);

endmodule

// File: rtl/error_checker_controller.sv
// Residual-check controller: sequences N samples through an external
// datapath computing y - (b0 + b1*x), one error word per sample, with a
// valid/ready handshake toward the consumer.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   start      - request a pass (honoured only in idle)
//   coefReady  - b0/b1 coefficients valid (level)
//   errReady   - consumer accepts the current error word
//   addr       - sample index to X/Y memory (always equals the counter)
//   ldX, ldY   - load sample registers
//   ldErr      - load residual register
//   errValid   - residual register holds an unaccepted result
//   busy       - pass in progress
//   done       - one-cycle pulse at pass completion
module error_checker_controller
    import error_checker_controller_pkg::*;
#(
    parameter int unsigned N  = 150,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          coefReady,
    input  logic          errReady,
    output logic [AW-1:0] addr,
    output logic          ldX,
    output logic          ldY,
    output logic          ldErr,
    output logic          errValid,
    output logic          busy,
    output logic          done
);

    ctrl_state_e state_q, state_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_tc;
    logic [AW-1:0] cnt_val;

    error_checker_controller_counter_modn #(
        .N  (N),
        .AW (AW)
    ) u_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt_val),
        .co_o    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        ldX      = 1'b0;
        ldY      = 1'b0;
        ldErr    = 1'b0;
        errValid = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        busy     = state_busy(state_q);

        case (state_q)
            StIdle: begin
                if (start) state_d = StWaitCoef;
            end
            StWaitCoef: begin
                if (coefReady) state_d = StInit;
            end
            StInit: begin
                cnt_clr = 1'b1;
                state_d = StLdXy;
            end
            StLdXy: begin
                ldX     = 1'b1;
                ldY     = 1'b1;
                state_d = StCalc;
            end
            StCalc: begin
                ldErr   = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                errValid = 1'b1;
                if (errReady) begin
                    // Last sample leaves the counter at N-1 so it never wraps.
                    if (cnt_tc) begin
                        state_d = StDone;
                    end else begin
                        cnt_en  = 1'b1;
                        state_d = StLdXy;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                // Illegal encoding: recover to idle with a clean counter.
                busy    = 1'b0;
                cnt_clr = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign addr = cnt_val;

endmodule
